// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
//
// Purpose:
//   Shared definitions for the registered N:1 channel multiplexer with
//   auto-scan (mux_nto1_scan) and its scan pointer helper (mux_scan_ptr).
//
// Contents:
//   MUX_MAX_CH   - largest channel count the block is built for.
//   mux_state_t  - controller state encoding (IDLE, MANUAL, SCAN).
//   clog2_min1() - ceil(log2(value)), never less than 1, for sizing
//                  counters that must keep at least one bit.
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam int MUX_MAX_CH = 256;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } mux_state_t;

    // A dwell of 1 or 2 cycles still needs a 1-bit counter.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/mux_scan_ptr.sv
// -----------------------------------------------------------------------------
// mux_scan_ptr
//
// Purpose:
//   Purely combinational channel-pointer logic for the scan mode of
//   mux_nto1_scan. Given the channel currently being shown and the per-channel
//   scan mask, it finds where the scan goes next.
//
// Ports:
//   i_cur     in  SEL_W  index of the channel currently selected
//   i_mask    in  N_CH   1 = channel takes part in the scan
//   o_next    out SEL_W  next higher enabled channel, or the lowest enabled
//                        channel when none is higher (wrap)
//   o_wrap    out 1      o_next is a wrap back to the lowest enabled channel
//   o_lowest  out SEL_W  lowest enabled channel (0 when mask is all zero)
//   o_any_en  out 1      at least one mask bit is set
// -----------------------------------------------------------------------------
module mux_scan_ptr
    import mux_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [SEL_W-1:0] i_cur,
    input  logic [N_CH-1:0]  i_mask,
    output logic [SEL_W-1:0] o_next,
    output logic             o_wrap,
    output logic [SEL_W-1:0] o_lowest,
    output logic             o_any_en
);

    logic             w_found_hi;
    logic [SEL_W-1:0] w_next_hi;
    logic [SEL_W-1:0] w_lowest;

    // Walk from the top index down so the last hit written is the lowest
    // qualifying index: the overall lowest enabled channel, and the lowest
    // enabled channel strictly above i_cur. Works even when the current
    // channel itself has just been de-masked.
    always_comb begin
        w_lowest   = '0;
        w_next_hi  = '0;
        w_found_hi = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (i_mask[k]) begin
                w_lowest = SEL_W'(k);
                if (k > int'(i_cur)) begin
                    w_next_hi  = SEL_W'(k);
                    w_found_hi = 1'b1;
                end
            end
        end
    end

    assign o_any_en = |i_mask;
    assign o_lowest = w_lowest;
    // A single enabled channel always "wraps" onto itself.
    assign o_wrap   = o_any_en && !w_found_hi;
    assign o_next   = w_found_hi ? w_next_hi : w_lowest;

endmodule

// File: rtl/mux_nto1_scan.sv
// -----------------------------------------------------------------------------
// mux_nto1_scan
//
// Purpose:
//   Parametrised, registered N:1 multiplexer placed between sensor/status
//   banks and a single downstream consumer. In manual mode the channel given
//   by sel is registered onto out one cycle later. In scan mode the block
//   steps through the channels enabled in mask, holding each for DWELL
//   cycles while re-sampling its live data every cycle.
//
// Build option:
//   MUX_SCAN_EN - when defined, the SCAN state, dwell counter, mask handling
//                 and scan_wrap pulse are built. When undefined the block is
//                 manual-only: mode and mask are ignored, scan_wrap is tied
//                 to 0, and the port list stays the same.
//
// Parameters:
//   N_CH   channel count (2..256)
//   DW     data width per channel
//   SEL_W  channel index width, derived from N_CH (do not override)
//   DWELL  cycles each channel is held while scanning (1..255)
//
// Ports:
//   clk        in  1        rising-edge clock
//   rst        in  1        synchronous active-high reset, wins over all
//   in         in  N_CH*DW  channel k at in[k*DW +: DW]
//   sel        in  SEL_W    manual channel select
//   mode       in  1        0 = manual, 1 = scan
//   en         in  1        update enable; 0 freezes every register
//   mask       in  N_CH     1 = channel included in the scan
//   out        out DW       registered selected data
//   out_sel    out SEL_W    index of the channel behind out
//   out_valid  out 1        out/out_sel hold a legal selection
//   scan_wrap  out 1        one-cycle pulse on the wrap to the first channel
//   dbg_state  out 2        controller state (mux_state_t encoding)
//
// Handshake: there is no backpressure. out/out_sel/out_valid change only on
// a clock edge where en=1; a consumer samples them whenever out_valid=1.
// -----------------------------------------------------------------------------
module mux_nto1_scan
    import mux_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int DW    = 1,
    parameter int SEL_W = $clog2(N_CH),
    parameter int DWELL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH*DW-1:0] in,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    input  logic               en,
    input  logic [N_CH-1:0]    mask,
    output logic [DW-1:0]      out,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    output logic               scan_wrap,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_MANUAL = ST_MANUAL;

    // Every select code gets a slot; codes past the last real channel read 0.
    localparam int SLOTS    = 1 << SEL_W;
    // Selects beyond the supported channel ceiling are never legal.
    localparam int N_CH_EFF = (N_CH < MUX_MAX_CH) ? N_CH : MUX_MAX_CH;

    // ------------------------------------------------------------------
    // Channel view of the packed input bus
    // ------------------------------------------------------------------
    logic [DW-1:0] w_ch [SLOTS];

    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        if (k < N_CH) begin : g_live
            assign w_ch[k] = in[k*DW +: DW];
        end else begin : g_pad
            assign w_ch[k] = '0;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [SEL_W-1:0] r_sel;
    logic [DW-1:0]    r_out;
    logic             r_valid;

    logic [1:0]       w_nxt_state;
    logic [SEL_W-1:0] w_nxt_sel;
    logic [DW-1:0]    w_nxt_out;
    logic             w_nxt_valid;

    // Manual path: out-of-range codes give out=0 through the padded slots.
    logic             w_man_ok;
    logic [DW-1:0]    w_man_out;

    assign w_man_ok  = (int'(sel) < N_CH_EFF);
    assign w_man_out = w_man_ok ? w_ch[sel] : '0;

`ifdef MUX_SCAN_EN
    // ------------------------------------------------------------------
    // Scan machinery
    // ------------------------------------------------------------------
    localparam logic [1:0]     S_SCAN   = ST_SCAN;
    localparam int             CNT_W    = clog2_min1(DWELL);
    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             r_wrap;
    logic             w_nxt_wrap;

    logic [SEL_W-1:0] w_next;
    logic             w_wrap;
    logic [SEL_W-1:0] w_lowest;
    logic             w_any_en;

    mux_scan_ptr #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_scan_ptr (
        .i_cur    (r_sel),
        .i_mask   (mask),
        .o_next   (w_next),
        .o_wrap   (w_wrap),
        .o_lowest (w_lowest),
        .o_any_en (w_any_en)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sel   = r_sel;
        w_nxt_out   = r_out;
        w_nxt_valid = r_valid;
        w_nxt_cnt   = r_cnt;
        w_nxt_wrap  = 1'b0;

        if (en) begin
            if (!mode) begin
                w_nxt_state = S_MANUAL;
                w_nxt_sel   = sel;
                w_nxt_out   = w_man_out;
                w_nxt_valid = w_man_ok;
                w_nxt_cnt   = '0;
            end else if (r_state != S_SCAN || !r_valid || !w_any_en) begin
                // Entering scan, resuming after an all-zero mask, or sitting
                // with nothing to scan: restart at the lowest enabled channel
                // (or park with out_valid=0). No wrap pulse here.
                w_nxt_state = S_SCAN;
                w_nxt_cnt   = '0;
                w_nxt_sel   = w_any_en ? w_lowest : '0;
                w_nxt_out   = w_any_en ? w_ch[w_lowest] : '0;
                w_nxt_valid = w_any_en;
            end else if (r_cnt == DWELL_M1) begin
                // Dwell finished: advance, pulsing scan_wrap on the same edge
                // that moves out_sel back to the first channel.
                w_nxt_cnt   = '0;
                w_nxt_sel   = w_next;
                w_nxt_out   = w_ch[w_next];
                w_nxt_wrap  = w_wrap;
            end else begin
                // Mid-dwell: keep the channel but track its live data.
                w_nxt_cnt   = r_cnt + CNT_W'(1);
                w_nxt_out   = w_ch[r_sel];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_nxt_cnt;
            r_wrap <= w_nxt_wrap;
        end
    end

    assign scan_wrap = r_wrap;
`else
    // Manual-only build: the scan inputs have no load.
    logic w_unused_scan;
    assign w_unused_scan = ^{mode, mask, 8'(DWELL)};

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sel   = r_sel;
        w_nxt_out   = r_out;
        w_nxt_valid = r_valid;

        if (en) begin
            w_nxt_state = S_MANUAL;
            w_nxt_sel   = sel;
            w_nxt_out   = w_man_out;
            w_nxt_valid = w_man_ok;
        end
    end

    assign scan_wrap = 1'b0;
`endif

    // en=0 holds everything because the next-state defaults are the
    // current register values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_sel   <= w_nxt_sel;
            r_out   <= w_nxt_out;
            r_valid <= w_nxt_valid;
        end
    end

    assign out       = r_out;
    assign out_sel   = r_sel;
    assign out_valid = r_valid;
    assign dbg_state = r_state;

endmodule

// File: doc/mux_nto1_scan.md
Name: mux_nto1_scan

Overview:
- Parametrised, registered N:1 multiplexer. Successor to the combinational 16:1 bit mux.
- Adds per-channel data width, a registered output with valid flag, and an auto-scan mode. In auto-scan the block steps through unmasked channels with a programmable dwell time.
- Sits between sensor/status banks and a single downstream consumer, for example a UART or logic probe.

Parameters:
- N_CH, 16, number of input channels (2..256).
- DW, 1, data width per channel in bits.
- SEL_W, $clog2(N_CH), select/channel-index width (derived; do not override).
- DWELL, 4, cycles each channel is held in scan mode (1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in  in  N_CH*DW  packed channel data; channel k occupies bits [k*DW +: DW].
- sel  in  SEL_W  manual channel select.
- mode  in  1  0 = manual, 1 = scan.
- en  in  1  enables output update; low freezes all state and outputs.
- mask  in  N_CH  scan enable per channel; 1 = channel included in scan.
- out  out  DW  registered selected data.
- out_sel  out  SEL_W  index of the channel currently driving out.
- out_valid  out  1  out/out_sel hold a legal selection.
- scan_wrap  out  1  one-cycle pulse when scan wraps from the last enabled channel to the first.

Behaviour:
- Reset, synchronous on rst=1 at a clock edge: out=0, out_sel=0, out_valid=0, scan_wrap=0, dwell counter=0, FSM=IDLE. Reset wins over every other input in the same cycle.
- FSM states are IDLE, MANUAL and SCAN.
  - IDLE -> MANUAL when en=1 and mode=0.
  - IDLE -> SCAN when en=1 and mode=1.
  - MANUAL <-> SCAN follows mode on any enabled cycle.
  - No return to IDLE except through reset.
- en=0: all registers hold, including FSM, counter and outputs. scan_wrap is forced 0.
- MANUAL:
  - Latency 1 cycle: out <= in[sel], out_sel <= sel, out_valid <= 1.
  - sel >= N_CH (non-power-of-2 N_CH only): out <= 0, out_valid <= 0, out_sel <= sel.
  - mask is ignored.
- SCAN entry (from IDLE or MANUAL): select the lowest-index channel with mask=1, clear the dwell counter, and register that channel's data the same edge. scan_wrap is not pulsed on entry.
- SCAN steady state:
  - out is re-sampled from the current channel every cycle, so data tracks live input.
  - The dwell counter increments each enabled cycle.
  - When the counter reaches DWELL-1: clear it and advance to the next higher-index channel with mask=1.
  - If no higher enabled channel exists, wrap to the lowest enabled channel and pulse scan_wrap on the same edge that out_sel changes.
- Single enabled channel: out_sel stays fixed and scan_wrap pulses every DWELL cycles.
- mask all zero in SCAN: out_valid <= 0, out <= 0, and the counter is held at 0.
  - Scanning resumes at the lowest enabled channel on the cycle after mask becomes nonzero.
- Current channel de-masked mid-dwell: finish the dwell, then advance normally.
- Mode change mid-dwell: the dwell is discarded. MANUAL takes effect on the next edge; SCAN re-enters per the entry rule.

Optional Feature:
- Macro: MUX_SCAN_EN.
- Defined: full SCAN state, dwell counter, mask and scan_wrap logic as above.
- Undefined:
  - SCAN state and counter are removed; mode and mask are ignored (left unconnected internally).
  - scan_wrap is tied to 0.
  - The block behaves as MANUAL whenever en=1.
  - The port list is unchanged.

Decomposition:
- Package mux_pkg holds:
  - the state enum (IDLE, MANUAL, SCAN);
  - constant MUX_MAX_CH=256;
  - the function clog2_min1 (returns at least 1).
- One sub-module, mux_scan_ptr (combinational):
  - inputs: current index and mask.
  - outputs: next enabled index, a wrap flag, the lowest enabled index, and an any_en flag.
- The top holds the FSM, dwell counter and output registers.

Test Plan:
- Manual, N_CH=16, DW=1, in=16'h3f0A: sel = 0, 1, 6, 12 on successive cycles -> out = 0, 1, 0, 1 one cycle later each; out_valid=1.
- DW=8, N_CH=4, in={8'hDD,8'hCC,8'hBB,8'hAA}: sel=2 -> out=8'hCC, out_sel=2 after 1 cycle.
- Scan, DWELL=3, mask=16'h0025 -> out_sel sequence 0,0,0,2,2,2,5,5,5,0. scan_wrap pulses exactly on the 5->0 edge.
- Scan with mask dropped to 0 mid-dwell -> out_valid=0 next cycle. Mask=16'h0010 restored -> out_sel=4, out_valid=1 the following cycle.
- en=0 for 5 cycles during scan -> out, out_sel and counter frozen. Scan resumes with the remaining dwell unchanged.
- rst=1 asserted together with en=1 in SCAN -> all outputs 0 next edge. FSM=IDLE, then re-enters on the first enabled cycle after rst drops.
